hazard_scoreboard: RTL and testbench

Issue-side hazard controller for the 5-stage pipelined MIPS CPU; the write-tracking counterpart to operand forwarding. Sits at the IF/ID boundary. Produces stall and flush controls for load-use hazards, taken branches resolved in MEM, and RAW/WAW/structural hazards against a non-pipelined multi-cycle multiplier tracked by a one-entry scoreboard.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_mul_tracker.sv | 77 +++++++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the issue-side hazard controller.
// Optional multiplier scoreboard is enabled by HAZ_MUL_SCOREBOARD_EN.
package hazard_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MUL_LAT_DEF = 4;
  localparam int         CNT_W_DEF   = 3;

  // Source/destination match that ignores the hardwired zero register.
  function automatic logic reg_match(
    input logic [4:0] a,
    input logic [4:0] b
  );
    return (a != REG_ZERO) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_mul_tracker.sv
// One-entry scoreboard for the non-pipelined multiplier.
// Tracks destination, remaining latency and wrong-path kill.
module mul_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  logic [4:0] rd_i,
  input  logic       branch_i,
  output logic       busy_o,
  output logic       last_o,
  output logic [4:0] pend_rd_o,
  output logic       done_o,
  output logic       kill_o
);

  state_e           state_q, state_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             age_q, age_d;

  // A branch in its first busy cycle means the multiply was fetched
  // on the wrong path; an older multiply is left to complete.
  assign busy_o    = (state_q == S_BUSY);
  assign last_o    = busy_o && (cnt_q == '0);
  assign kill_o    = busy_o && age_q && branch_i;
  assign done_o    = last_o && !kill_o;
  assign pend_rd_o = pend_rd_q;

  // Next-state: issue loads the entry, busy counts down to writeback.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    cnt_d     = cnt_q;
    age_d     = age_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue_i) begin
          state_d   = S_BUSY;
          pend_rd_d = rd_i;
          cnt_d     = CNT_W'(MUL_LAT - 1);
          age_d     = 1'b1;
        end
      end
      S_BUSY: begin
        age_d = 1'b0;
        if (kill_o || last_o) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pend_rd_q <= REG_ZERO;
      cnt_q     <= '0;
      age_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      cnt_q     <= cnt_d;
      age_q     <= age_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// IF/ID hazard controller: load-use, branch flush, multiplier scoreboard.
// Scoreboard logic present only when HAZ_MUL_SCOREBOARD_EN is defined.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic [4:0] IF_ID_rd,
  input  logic       IF_ID_regwrite,
  input  logic       IF_ID_is_mul,
  input  logic       ID_EX_memread,
  input  logic [4:0] ID_EX_rt,
  input  logic       branch_taken_i,
  output logic       pc_write_o,
  output logic       if_id_write_o,
  output logic       if_flush_o,
  output logic       id_flush_o,
  output logic       ex_flush_o,
  output logic       mul_issue_o,
  output logic       mul_busy_o,
  output logic       mul_kill_o,
  output logic       mul_done_o
);

  logic load_use;
  logic sb_hit;
  logic stall;

  assign load_use = ID_EX_memread &&
                    (reg_match(ID_EX_rt, IF_ID_rs) ||
                     reg_match(ID_EX_rt, IF_ID_rt));

`ifdef HAZ_MUL_SCOREBOARD_EN
  logic       busy;
  logic       last;
  logic [4:0] pend_rd;
  logic       raw;
  logic       waw;
  logic       structural;

  mul_tracker #(
    .MUL_LAT (MUL_LAT),
    .CNT_W   (CNT_W)
  ) u_trk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .issue_i   (mul_issue_o),
    .rd_i      (IF_ID_rd),
    .branch_i  (branch_taken_i),
    .busy_o    (busy),
    .last_o    (last),
    .pend_rd_o (pend_rd),
    .done_o    (mul_done_o),
    .kill_o    (mul_kill_o)
  );

  // Result is written through the register file in the done cycle, so
  // data hazards clear there; the unit itself is still occupied.
  assign raw = busy && !last &&
               (reg_match(pend_rd, IF_ID_rs) ||
                reg_match(pend_rd, IF_ID_rt));
  assign waw = busy && !last && IF_ID_regwrite &&
               reg_match(pend_rd, IF_ID_rd);
  assign structural = busy && IF_ID_is_mul;
  assign sb_hit     = raw || waw || structural;

  assign mul_busy_o  = busy;
  assign mul_issue_o = IF_ID_is_mul && !stall &&
                       !branch_taken_i && !busy;
`else
  logic unused_ok;

  assign unused_ok   = ^{clk_i, rst_i, IF_ID_rd,
                         IF_ID_regwrite, IF_ID_is_mul};
  assign sb_hit      = 1'b0;
  assign mul_issue_o = 1'b0;
  assign mul_busy_o  = 1'b0;
  assign mul_kill_o  = 1'b0;
  assign mul_done_o  = 1'b0;
`endif

  assign stall = (load_use || sb_hit) && !branch_taken_i;

  // Pipeline controls: taken branch overrides any stall.
  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_flush_o    = 1'b0;
    id_flush_o    = 1'b0;
    ex_flush_o    = 1'b0;
    unique case (1'b1)
      branch_taken_i: begin
        if_flush_o = 1'b1;
        id_flush_o = 1'b1;
        ex_flush_o = 1'b1;
      end
      stall: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_flush_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Output vector: {pc,ifid,iff,idf,exf,issue,busy,kill,done}.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] IF_ID_rs, IF_ID_rt, IF_ID_rd;
  logic       IF_ID_regwrite, IF_ID_is_mul;
  logic       ID_EX_memread;
  logic [4:0] ID_EX_rt;
  logic       branch_taken_i;
  logic       pc_write_o, if_id_write_o;
  logic       if_flush_o, id_flush_o, ex_flush_o;
  logic       mul_issue_o, mul_busy_o, mul_kill_o, mul_done_o;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [8:0] NORM  = 9'b110000000;
  localparam logic [8:0] STALL = 9'b000100000;
  localparam logic [8:0] BR    = 9'b111110000;
  localparam logic [8:0] ISS   = 9'b000001000;
  localparam logic [8:0] BUSY  = 9'b000000100;
  localparam logic [8:0] KILL  = 9'b000000010;
  localparam logic [8:0] DONE  = 9'b000000001;

  hazard_scoreboard #(.MUL_LAT(4), .CNT_W(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .IF_ID_rd       (IF_ID_rd),
    .IF_ID_regwrite (IF_ID_regwrite),
    .IF_ID_is_mul   (IF_ID_is_mul),
    .ID_EX_memread  (ID_EX_memread),
    .ID_EX_rt       (ID_EX_rt),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc_write_o),
    .if_id_write_o  (if_id_write_o),
    .if_flush_o     (if_flush_o),
    .id_flush_o     (id_flush_o),
    .ex_flush_o     (ex_flush_o),
    .mul_issue_o    (mul_issue_o),
    .mul_busy_o     (mul_busy_o),
    .mul_kill_o     (mul_kill_o),
    .mul_done_o     (mul_done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    IF_ID_rs       = 5'd0;
    IF_ID_rt       = 5'd0;
    IF_ID_rd       = 5'd0;
    IF_ID_regwrite = 1'b0;
    IF_ID_is_mul   = 1'b0;
    ID_EX_memread  = 1'b0;
    ID_EX_rt       = 5'd0;
    branch_taken_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    #1;
    got = {pc_write_o, if_id_write_o, if_flush_o, id_flush_o,
           ex_flush_o, mul_issue_o, mul_busy_o, mul_kill_o,
           mul_done_o};
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  initial begin
    clr();
    rst_i = 1'b1;
    tick();
    tick();
    chk("reset", NORM);
    rst_i = 1'b0;
    tick();
    chk("idle", NORM);

    ID_EX_memread = 1'b1; ID_EX_rt = 5'd9; IF_ID_rs = 5'd9;
    chk("lu_rs", STALL);
    tick();
    ID_EX_memread = 1'b0; ID_EX_rt = 5'd0;
    chk("lu_next", NORM);
    clr();
    ID_EX_memread = 1'b1; ID_EX_rt = 5'd9; IF_ID_rt = 5'd9;
    chk("lu_rt", STALL);
    clr();
    ID_EX_memread = 1'b1; ID_EX_rt = 5'd9; IF_ID_rs = 5'd7;
    chk("lu_nomatch", NORM);
    clr();
    ID_EX_memread = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0;
    chk("lu_r0", NORM);
    clr();
    ID_EX_memread = 1'b1; ID_EX_rt = 5'd9; IF_ID_rs = 5'd9;
    branch_taken_i = 1'b1;
    chk("lu_branch", BR);
    clr();
    tick();

`ifdef HAZ_MUL_SCOREBOARD_EN
    IF_ID_is_mul = 1'b1; IF_ID_rd = 5'd8; IF_ID_regwrite = 1'b1;
    IF_ID_rs = 5'd1; IF_ID_rt = 5'd2;
    chk("mul_issue", NORM | ISS);
    tick();
    clr(); IF_ID_rt = 5'd8;
    chk("raw_k1", STALL | BUSY);
    tick();
    chk("raw_k2", STALL | BUSY);
    tick();
    chk("raw_k3", STALL | BUSY);
    tick();
    chk("raw_done", NORM | BUSY | DONE);
    tick();
    chk("raw_after", NORM);

    clr(); IF_ID_is_mul = 1'b1; IF_ID_rd = 5'd10;
    chk("st_issue", NORM | ISS);
    tick();
    IF_ID_rd = 5'd11; IF_ID_rs = 5'd3; IF_ID_rt = 5'd4;
    chk("st_k1", STALL | BUSY);
    tick();
    tick();
    chk("st_k3", STALL | BUSY);
    tick();
    chk("st_done", STALL | BUSY | DONE);
    tick();
    chk("st_reissue", NORM | ISS);
    tick();
    clr(); branch_taken_i = 1'b1;
    chk("kill", BR | BUSY | KILL);
    tick();
    clr();
    chk("kill_idle", NORM);

    IF_ID_is_mul = 1'b1; IF_ID_rd = 5'd12;
    tick();
    clr();
    tick();
    branch_taken_i = 1'b1;
    chk("br_age0", BR | BUSY);
    tick();
    clr();
    chk("age0_k3", NORM | BUSY);
    tick();
    chk("age0_done", NORM | BUSY | DONE);
    tick();
    chk("age0_idle", NORM);

    IF_ID_is_mul = 1'b1; IF_ID_rd = 5'd13;
    tick();
    clr(); IF_ID_regwrite = 1'b1; IF_ID_rd = 5'd13;
    IF_ID_rs = 5'd5; IF_ID_rt = 5'd6;
    chk("waw", STALL | BUSY);
    IF_ID_regwrite = 1'b0;
    chk("no_waw", NORM | BUSY);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clr();
    chk("rst_mid", NORM);
    tick();
    chk("rst_quiet", NORM);

    IF_ID_is_mul = 1'b1; IF_ID_rd = 5'd0;
    tick();
    clr(); IF_ID_regwrite = 1'b1;
    chk("r0_nostall", NORM | BUSY);
    tick();
    tick();
    tick();
    clr();
    chk("r0_done", NORM | BUSY | DONE);
`else
    IF_ID_is_mul = 1'b1; IF_ID_rd = 5'd8;
    chk("nomul_issue", NORM);
    tick();
    clr(); IF_ID_rt = 5'd8; IF_ID_is_mul = 1'b1;
    chk("nomul_nostall", NORM);
    branch_taken_i = 1'b1;
    chk("nomul_branch", BR);
    clr();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
